maptable_recovery_ctrl: RTL and testbench
=========================================

# maptable_recovery_ctrl

Sequencer that restores the speculative rename map table from the architectural map table after a branch mispredict or exception. It sits between the retire stage, the architectural map and the rename map. It blocks dispatch and retirement, waits for the ROB/RS purge, then copies all 32 architectural tags into the rename map, LANES entries per cycle. It pulses done when the rename map is consistent again.

## Interface
- PREG_W, $clog2(`N_ENTRY_ROB+33): physical tag width, shared with the architectural map.
- LANES, 4: rename-map write ports used per copy cycle. Must be a power of two and must divide 32.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (asserted at 0). All state clears immediately on assertion.
- recover_req  in  1  mispredict/exception request. Level is sampled only in IDLE.
- flush_done  in  1  ROB/RS purge complete. Sampled only in FLUSH.
- arch_tag  in  32×PREG_W  live architectural map contents, read combinationally.
- flush_req  out  1  purge request to ROB/RS.
- dispatch_stall  out  1  freezes rename/dispatch.
- retire_block  out  1  inhibits architectural-map updates (gates valid_0/valid_1).
- rmt_wr_en  out  LANES  per-lane rename-map write enable.
- rmt_wr_idx  out  LANES×5  architectural register index per lane.
- rmt_wr_tag  out  LANES×PREG_W  tag per lane (arch_tag[rmt_wr_idx]).
- recover_done  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FLUSH, COPY, DONE. Encoding is a 2-bit enum. The copy pointer ptr is 5-log2(LANES) bits wide.
- IDLE:
  - All outputs are 0.
  - recover_req=1 → FLUSH.
- FLUSH:
  - flush_req, dispatch_stall, retire_block and busy are 1.
  - Stay in FLUSH until flush_done=1, then go to COPY with ptr=0.
- COPY:
  - dispatch_stall, retire_block and busy are 1; flush_req is 0.
  - Lane l (0..LANES-1): rmt_wr_en[l]=1, rmt_wr_idx[l]=ptr*LANES+l, rmt_wr_tag[l]=arch_tag[ptr*LANES+l].
  - ptr increments each cycle.
  - On the last group (ptr=32/LANES-1), go to DONE.
- DONE:
  - recover_done=1, dispatch_stall=1, busy=1; retire_block is 0.
  - Unconditionally → IDLE.
- Register 0 is copied like any other entry; no special case.
- recover_req in FLUSH, COPY or DONE is ignored. The in-flight recovery already covers it, since the ROB is purged.
- A retirement in the same cycle recover_req is first seen in IDLE still commits at that edge. The copy therefore reflects it.
- flush_done outside FLUSH is ignored.
- rmt_wr_en is 0 outside COPY. rmt_wr_idx and rmt_wr_tag are don't-care when rmt_wr_en is 0; drive them to 0.
- Reset asserted in any state: go to IDLE immediately, ptr=0, all outputs 0. No partial write may be flagged after reset.

## Timing
- recover_req high at edge k (in IDLE): FLUSH outputs are valid in cycle k+1.
- flush_done high at edge m (in FLUSH): COPY runs for cycles m+1 .. m+32/LANES (8 cycles at LANES=4).
- DONE is in cycle m+32/LANES+1. IDLE follows on the next cycle, and dispatch_stall drops then.
- flush_done already high on the first FLUSH cycle gives the minimum total: 1 FLUSH cycle + 32/LANES COPY cycles + 1 DONE cycle.
- Outputs are a registered-state decode; rmt_wr_tag is a combinational path from arch_tag through the lane mux.
- Retirement is blocked from the first FLUSH cycle through the last COPY cycle. This guarantees arch_tag is stable while it is being copied.

## Structure
- Shared package (e.g. `sys_defs`):
  - recovery state enum.
  - PREG_W definition.
  - ARCH_REGS=32 constant.
  - LANES default.
- One natural sub-module: maptable_copy_lane_mux, which selects LANES tags from arch_tag given ptr. It is purely combinational and reused by the checkpoint logic.
- The FSM and pointer live in the top module.

## Test plan
- Basic recovery:
  - arch_tag[i]=i+40, LANES=4.
  - recover_req pulse at cycle 0; flush_done at cycle 3.
  - Required: COPY in cycles 4–11 writing indices 0–31 with tags 40–71, four per cycle in order.
  - recover_done in cycle 12; dispatch_stall low in cycle 13.
- Immediate flush_done:
  - flush_done held at 1.
  - Required: total busy span is exactly 10 cycles; flush_req high for exactly 1 cycle.
- Request while busy:
  - recover_req re-pulsed during COPY (cycle 6).
  - Required: no restart, ptr keeps counting, exactly one recover_done pulse.
- Reset mid-COPY:
  - reset=0 at cycle 7, asynchronously between edges.
  - Required: rmt_wr_en=0 and busy=0 before the next edge; IDLE after release; a new request copies all 32 entries from index 0.
- Retire coincident with request:
  - Arch map updates tag[5] from 5 to 50 at edge 0, with recover_req also at edge 0.
  - Required: rmt_wr_tag for index 5 equals 50.
  - Required: retire_block is high from cycle 1 until recover_done.
- Spurious flush_done:
  - flush_done=1 while in IDLE.
  - Required: no state change; all outputs remain 0.

Source files
------------

// File: rtl/maptable_recovery_ctrl_pkg.sv
// Shared definitions for the map-table recovery sequencer: physical tag
// width, architectural register count, default copy width and FSM states.
`ifndef N_ENTRY_ROB
`define N_ENTRY_ROB 32
`endif

package maptable_recovery_ctrl_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int ARCH_IDX_W = 5;
  localparam int PREG_W     = $clog2(`N_ENTRY_ROB + 33);
  localparam int LANES_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_COPY  = 2'd2,
    ST_DONE  = 2'd3
  } rec_state_e;

  // Copy pointer width: one count per group of LANES registers, never below 1 bit.
  function automatic int ptr_width(input int lanes);
    return ((ARCH_IDX_W - $clog2(lanes)) < 1) ? 1 : (ARCH_IDX_W - $clog2(lanes));
  endfunction

endpackage

// File: rtl/maptable_recovery_ctrl_if.sv
// Recovery handshake and rename-map write bus. The master side is the
// pipeline (retire/ROB/arch map), the slave side is the recovery sequencer.
interface maptable_recovery_ctrl_if
  import maptable_recovery_ctrl_pkg::*;
#(
  parameter int LANES = LANES_DEF
) ();

  logic                              recover_req;
  logic                              flush_done;
  logic [ARCH_REGS-1:0][PREG_W-1:0]  arch_tag;

  logic                              flush_req;
  logic                              dispatch_stall;
  logic                              retire_block;
  logic [LANES-1:0]                  rmt_wr_en;
  logic [LANES-1:0][ARCH_IDX_W-1:0]  rmt_wr_idx;
  logic [LANES-1:0][PREG_W-1:0]      rmt_wr_tag;
  logic                              recover_done;
  logic                              busy;

  modport master (
    output recover_req, flush_done, arch_tag,
    input  flush_req, dispatch_stall, retire_block,
           rmt_wr_en, rmt_wr_idx, rmt_wr_tag, recover_done, busy
  );

  modport slave (
    input  recover_req, flush_done, arch_tag,
    output flush_req, dispatch_stall, retire_block,
           rmt_wr_en, rmt_wr_idx, rmt_wr_tag, recover_done, busy
  );

endinterface

// File: rtl/maptable_recovery_ctrl_copy_lane_mux.sv
// maptable_copy_lane_mux: purely combinational selector that presents the
// LANES architectural tags of copy group ptr, with their register indices.
// Also used by the checkpoint logic, so it carries no state.
module maptable_copy_lane_mux
  import maptable_recovery_ctrl_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int PTR_W = ptr_width(LANES)
) (
  input  logic [ARCH_REGS-1:0][PREG_W-1:0]  i_arch_tag,
  input  logic [PTR_W-1:0]                  i_ptr,
  output logic [LANES-1:0][ARCH_IDX_W-1:0]  o_idx,
  output logic [LANES-1:0][PREG_W-1:0]      o_tag
);

  localparam int LOG_L = $clog2(LANES);

  logic [ARCH_IDX_W-1:0] w_base;

  // First register index of the group is ptr*LANES.
  assign w_base = ARCH_IDX_W'(i_ptr) << LOG_L;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign o_idx[l] = w_base + ARCH_IDX_W'(l);
    assign o_tag[l] = i_arch_tag[o_idx[l]];
  end

endmodule

// File: rtl/maptable_recovery_ctrl.sv
// Recovery sequencer: on a mispredict/exception it stalls dispatch, blocks
// retirement, requests a ROB/RS purge, then copies the architectural map
// into the rename map LANES entries per cycle and pulses recover_done.
module maptable_recovery_ctrl
  import maptable_recovery_ctrl_pkg::*;
#(
  parameter int LANES = LANES_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  maptable_recovery_ctrl_if.slave bus
);

  localparam int               PTR_W    = ptr_width(LANES);
  localparam int               GROUPS   = ARCH_REGS / LANES;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(GROUPS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  rec_state_e       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_flush_req;
  logic             r_dispatch_stall;
  logic             r_retire_block;
  logic             r_busy;
  logic             r_done;
  logic [LANES-1:0] r_wr_en;

  logic [LANES-1:0][ARCH_IDX_W-1:0] w_mux_idx;
  logic [LANES-1:0][PREG_W-1:0]     w_mux_tag;
  logic [LANES-1:0][ARCH_IDX_W-1:0] w_wr_idx;
  logic [LANES-1:0][PREG_W-1:0]     w_wr_tag;

  maptable_copy_lane_mux #(
    .LANES (LANES),
    .PTR_W (PTR_W)
  ) u_lane_mux (
    .i_arch_tag (bus.arch_tag),
    .i_ptr      (r_ptr),
    .o_idx      (w_mux_idx),
    .o_tag      (w_mux_tag)
  );

  // Recovery FSM; outputs are registered as the decode of the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= ST_IDLE;
      r_ptr            <= PTR_ZERO;
      r_flush_req      <= 1'b0;
      r_dispatch_stall <= 1'b0;
      r_retire_block   <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_wr_en          <= {LANES{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Retirement in this same cycle still commits: retire_block rises only after this edge.
          if (bus.recover_req) begin
            r_state          <= ST_FLUSH;
            r_flush_req      <= 1'b1;
            r_dispatch_stall <= 1'b1;
            r_retire_block   <= 1'b1;
            r_busy           <= 1'b1;
          end else begin
            r_state          <= ST_IDLE;
            r_flush_req      <= 1'b0;
            r_dispatch_stall <= 1'b0;
            r_retire_block   <= 1'b0;
            r_busy           <= 1'b0;
          end
          r_ptr   <= PTR_ZERO;
          r_done  <= 1'b0;
          r_wr_en <= {LANES{1'b0}};
        end
        ST_FLUSH: begin
          if (bus.flush_done) begin
            r_state     <= ST_COPY;
            r_flush_req <= 1'b0;
            r_wr_en     <= {LANES{1'b1}};
          end else begin
            r_state     <= ST_FLUSH;
            r_flush_req <= 1'b1;
            r_wr_en     <= {LANES{1'b0}};
          end
          r_ptr            <= PTR_ZERO;
          r_dispatch_stall <= 1'b1;
          r_retire_block   <= 1'b1;
          r_busy           <= 1'b1;
          r_done           <= 1'b0;
        end
        ST_COPY: begin
          if (r_ptr == LAST_PTR) begin
            r_state        <= ST_DONE;
            r_ptr          <= PTR_ZERO;
            r_wr_en        <= {LANES{1'b0}};
            r_retire_block <= 1'b0;
            r_done         <= 1'b1;
          end else begin
            r_state        <= ST_COPY;
            r_ptr          <= r_ptr + PTR_ONE;
            r_wr_en        <= {LANES{1'b1}};
            r_retire_block <= 1'b1;
            r_done         <= 1'b0;
          end
          r_flush_req      <= 1'b0;
          r_dispatch_stall <= 1'b1;
          r_busy           <= 1'b1;
        end
        ST_DONE: begin
          r_state          <= ST_IDLE;
          r_ptr            <= PTR_ZERO;
          r_flush_req      <= 1'b0;
          r_dispatch_stall <= 1'b0;
          r_retire_block   <= 1'b0;
          r_busy           <= 1'b0;
          r_done           <= 1'b0;
          r_wr_en          <= {LANES{1'b0}};
        end
        default: begin
          r_state          <= ST_IDLE;
          r_ptr            <= PTR_ZERO;
          r_flush_req      <= 1'b0;
          r_dispatch_stall <= 1'b0;
          r_retire_block   <= 1'b0;
          r_busy           <= 1'b0;
          r_done           <= 1'b0;
          r_wr_en          <= {LANES{1'b0}};
        end
      endcase
    end
  end

  // Lane index/tag are forced to zero on lanes that are not writing.
  always_comb begin
    w_wr_idx = {(LANES*ARCH_IDX_W){1'b0}};
    w_wr_tag = {(LANES*PREG_W){1'b0}};
    for (int l = 0; l < LANES; l++) begin
      if (r_wr_en[l]) begin
        w_wr_idx[l] = w_mux_idx[l];
        w_wr_tag[l] = w_mux_tag[l];
      end else begin
        w_wr_idx[l] = {ARCH_IDX_W{1'b0}};
        w_wr_tag[l] = {PREG_W{1'b0}};
      end
    end
  end

  assign bus.flush_req      = r_flush_req;
  assign bus.dispatch_stall = r_dispatch_stall;
  assign bus.retire_block   = r_retire_block;
  assign bus.busy           = r_busy;
  assign bus.recover_done   = r_done;
  assign bus.rmt_wr_en      = r_wr_en;
  assign bus.rmt_wr_idx     = w_wr_idx;
  assign bus.rmt_wr_tag     = w_wr_tag;

endmodule

// File: tb/tb_maptable_recovery_ctrl.sv
// Bench for maptable_recovery_ctrl: a schedule-based reference model plus
// directed scenarios with literal expectations.
module tb_maptable_recovery_ctrl;
  import maptable_recovery_ctrl_pkg::*;

  localparam int NL = 4;

  logic clk;
  logic rst_n;

  maptable_recovery_ctrl_if #(.LANES(NL)) u_if ();

  maptable_recovery_ctrl #(.LANES(NL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done_seen = 0;

  // Architectural map held by the bench; retirement is gated by retire_block.
  logic [PREG_W-1:0] arch_mem [ARCH_REGS];
  logic        arch_load;
  int          arch_base;
  logic        ret_valid;
  logic [4:0]  ret_idx;
  logic [PREG_W-1:0] ret_tag;

  always @(posedge clk) begin
    if (arch_load) begin
      for (int i = 0; i < ARCH_REGS; i++) arch_mem[i] <= PREG_W'(i + arch_base);
    end else if (ret_valid && !u_if.retire_block) begin
      arch_mem[ret_idx] <= ret_tag;
    end
  end

  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) u_if.arch_tag[i] = arch_mem[i];
  end

  // Reference model: idle, waiting for purge, or replaying a schedule of
  // per-cycle records (copy group number, or -1 for the completion cycle).
  logic m_flushing;
  int   m_sched[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flushing <= 1'b0;
      m_sched.delete();
    end else if (m_sched.size() != 0) begin
      void'(m_sched.pop_front());
    end else if (m_flushing) begin
      if (u_if.flush_done) begin
        m_flushing <= 1'b0;
        for (int g = 0; g < ARCH_REGS / NL; g++) m_sched.push_back(g);
        m_sched.push_back(-1);
      end
    end else if (u_if.recover_req) begin
      m_flushing <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : cmp
    logic e_fr, e_st, e_rb, e_busy, e_done, e_en;
    int   e_grp;
    int   ei;
    if (rst_n) begin
      e_fr = 1'b0; e_st = 1'b0; e_rb = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0;
      e_grp = 0;
      if (m_sched.size() != 0) begin
        e_st = 1'b1; e_busy = 1'b1;
        if (m_sched[0] < 0) begin
          e_done = 1'b1;
        end else begin
          e_rb = 1'b1; e_en = 1'b1; e_grp = m_sched[0];
        end
      end else if (m_flushing) begin
        e_fr = 1'b1; e_st = 1'b1; e_rb = 1'b1; e_busy = 1'b1;
      end
      check("flush_req", 32'(u_if.flush_req), 32'(e_fr));
      check("dispatch_stall", 32'(u_if.dispatch_stall), 32'(e_st));
      check("retire_block", 32'(u_if.retire_block), 32'(e_rb));
      check("busy", 32'(u_if.busy), 32'(e_busy));
      check("recover_done", 32'(u_if.recover_done), 32'(e_done));
      for (int l = 0; l < NL; l++) begin
        ei = e_grp * NL + l;
        check($sformatf("wr_en%0d", l), 32'(u_if.rmt_wr_en[l]), 32'(e_en));
        check($sformatf("wr_idx%0d", l), 32'(u_if.rmt_wr_idx[l]), e_en ? 32'(ei) : 32'd0);
        check($sformatf("wr_tag%0d", l), 32'(u_if.rmt_wr_tag[l]), e_en ? 32'(arch_mem[ei]) : 32'd0);
      end
      if (u_if.recover_done) n_done_seen <= n_done_seen + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt, fr_cnt, rb_cnt, d0;
  logic [31:0] mask;

  initial begin
    rst_n = 1'b0;
    u_if.recover_req = 1'b0;
    u_if.flush_done  = 1'b0;
    ret_valid = 1'b0; ret_idx = 5'd0; ret_tag = '0;
    arch_load = 1'b1; arch_base = 40;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_wr_en", 32'(u_if.rmt_wr_en), 32'd0);
    check("rst_stall", 32'(u_if.dispatch_stall), 32'd0);
    tick(); tick();
    rst_n = 1'b1; arch_load = 1'b0;
    tick();

    // Basic recovery: request at edge 0, flush_done at edge 3
    u_if.recover_req = 1'b1; tick(); u_if.recover_req = 1'b0;
    tick(); tick();
    u_if.flush_done = 1'b1; tick(); u_if.flush_done = 1'b0;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      check("basic_wr_en", 32'(u_if.rmt_wr_en), 32'hF);
      for (int l = 0; l < NL; l++) begin
        check("basic_idx", 32'(u_if.rmt_wr_idx[l]), 32'(4 * g + l));
        check("basic_tag", 32'(u_if.rmt_wr_tag[l]), 32'(40 + 4 * g + l));
      end
      tick();
    end
    @(negedge clk);
    check("basic_done", 32'(u_if.recover_done), 32'd1);
    check("basic_done_stall", 32'(u_if.dispatch_stall), 32'd1);
    tick();
    @(negedge clk);
    check("basic_stall_drop", 32'(u_if.dispatch_stall), 32'd0);
    check("basic_idle_busy", 32'(u_if.busy), 32'd0);
    tick();

    // Immediate flush_done: minimum-length recovery
    u_if.flush_done = 1'b1;
    u_if.recover_req = 1'b1; tick(); u_if.recover_req = 1'b0;
    busy_cnt = 0; fr_cnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (u_if.busy) busy_cnt++;
      if (u_if.flush_req) fr_cnt++;
      tick();
    end
    u_if.flush_done = 1'b0;
    check("min_busy_span", 32'(busy_cnt), 32'd10);
    check("min_flush_req", 32'(fr_cnt), 32'd1);

    // Request while busy: re-pulse in COPY cycle 6
    d0 = n_done_seen;
    u_if.recover_req = 1'b1; tick(); u_if.recover_req = 1'b0;
    u_if.flush_done = 1'b1; tick(); u_if.flush_done = 1'b0;
    repeat (4) tick();
    u_if.recover_req = 1'b1; tick(); u_if.recover_req = 1'b0;
    repeat (10) tick();
    check("busy_req_done_pulses", 32'(n_done_seen - d0), 32'd1);
    check("busy_req_idle", 32'(u_if.busy), 32'd0);

    // Reset asserted between edges in COPY cycle 7
    u_if.recover_req = 1'b1; u_if.flush_done = 1'b1; tick();
    u_if.recover_req = 1'b0; tick(); u_if.flush_done = 1'b0;
    repeat (5) tick();
    check("pre_rst_wr_en", 32'(u_if.rmt_wr_en), 32'hF);
    #2; rst_n = 1'b0; #1;
    check("async_rst_wr_en", 32'(u_if.rmt_wr_en), 32'd0);
    check("async_rst_busy", 32'(u_if.busy), 32'd0);
    check("async_rst_stall", 32'(u_if.dispatch_stall), 32'd0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(u_if.busy), 32'd0);
    tick();
    u_if.recover_req = 1'b1; u_if.flush_done = 1'b1; tick();
    u_if.recover_req = 1'b0; tick(); u_if.flush_done = 1'b0;
    mask = 32'd0;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      if (g == 0) begin
        check("rerun_first_idx", 32'(u_if.rmt_wr_idx[0]), 32'd0);
        check("rerun_first_tag", 32'(u_if.rmt_wr_tag[0]), 32'd40);
      end
      for (int l = 0; l < NL; l++) begin
        if (u_if.rmt_wr_en[l]) mask[u_if.rmt_wr_idx[l]] = 1'b1;
      end
      tick();
    end
    check("rerun_all_entries", mask, 32'hFFFF_FFFF);
    tick(); tick();

    // Retire coincident with request: tag[5] 5 -> 50 at edge 0
    arch_base = 0; arch_load = 1'b1; tick(); arch_load = 1'b0;
    u_if.recover_req = 1'b1; ret_valid = 1'b1; ret_idx = 5'd5; ret_tag = PREG_W'(50);
    tick();
    u_if.recover_req = 1'b0; ret_idx = 5'd6; ret_tag = PREG_W'(99);
    u_if.flush_done = 1'b1;
    rb_cnt = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (u_if.retire_block) rb_cnt++;
      if (c == 3) begin
        check("retire_idx5", 32'(u_if.rmt_wr_idx[1]), 32'd5);
        check("retire_tag5", 32'(u_if.rmt_wr_tag[1]), 32'd50);
        check("blocked_tag6", 32'(u_if.rmt_wr_tag[2]), 32'd6);
      end
      tick();
      if (c == 1) u_if.flush_done = 1'b0;
      if (c == 3) ret_valid = 1'b0;
    end
    check("retire_block_span", 32'(rb_cnt), 32'd9);

    // Spurious flush_done in IDLE
    u_if.flush_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_busy", 32'(u_if.busy), 32'd0);
      check("spur_flush_req", 32'(u_if.flush_req), 32'd0);
      check("spur_wr_en", 32'(u_if.rmt_wr_en), 32'd0);
      tick();
    end
    u_if.flush_done = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
